count_seq_checker: RTL and testbench

Streaming monitor placed directly downstream of the 4-bit synchronous up counter.
- Samples the counter's `count` output every clock and verifies that each valid sample equals the previous valid sample plus one, modulo 2^WIDTH.
- Reports wrap-arounds and step faults as one-cycle pulses, saturating event counters and a sticky error flag.
- Used in-system as a health check and in benches as a self-checking consumer of the counter.

---
 rtl/count_chk_pkg.sv | 12 +
 rtl/sat_counter.sv | 23 ++
 rtl/count_seq_checker.sv | 113 +++++++++++
 tb/tb_count_seq_checker.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/count_chk_pkg.sv
// Shared types and constants for the counter sequence checker.
package count_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam int RECOVER_MATCHES = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
// Latency 1 cycle; no backpressure, holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/count_seq_checker.sv
// Checks that valid count samples step by +1 mod 2^WIDTH; flags wraps and faults.
// Latency 1 cycle, all outputs registered; no backpressure (pure monitor).
module count_seq_checker #(
  parameter int WIDTH      = 4,
  parameter int WRAP_CNT_W = 8,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      count_in,
  input  logic                  valid_in,
  input  logic                  clear,
  output logic                  wrap_pulse,
  output logic [WRAP_CNT_W-1:0] wrap_count,
  output logic                  err_pulse,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic                  err_sticky,
  output logic [1:0]            state
);

  import count_chk_pkg::*;

  state_t           st;
  logic [WIDTH-1:0] prev;
  logic             good_run;
  logic [WIDTH-1:0] expected;
  logic             is_match;
  logic             mismatch_ev;
  logic             wrap_ev;

  assign expected    = prev + WIDTH'(1);
  assign is_match    = (count_in == expected);
  assign mismatch_ev = valid_in && ((st == TRACK) || (st == FAULT)) && !is_match;
  // Only wraps seen while healthy are counted.
  assign wrap_ev     = valid_in && (st == TRACK) && is_match && (prev == {WIDTH{1'b1}});
  assign state       = st;

  always_ff @(posedge clk) begin
    if (!rst) begin
      st         <= IDLE;
      prev       <= '0;
      good_run   <= 1'b0;
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      wrap_pulse <= wrap_ev;
      err_pulse  <= mismatch_ev;
      if (clear) begin
        err_sticky <= 1'b0;
      end else if (mismatch_ev) begin
        err_sticky <= 1'b1;
      end

      case (st)
        IDLE: begin
          if (valid_in) begin
            prev <= count_in;
            st   <= TRACK;
          end
        end
        TRACK: begin
          if (!valid_in) begin
            st <= IDLE;
          end else begin
            prev <= count_in;
            if (!is_match) begin
              st       <= FAULT;
              good_run <= 1'b0;
            end
          end
        end
        FAULT: begin
          if (!valid_in) begin
            st       <= IDLE;
            good_run <= 1'b0;
          end else begin
            prev <= count_in;
            if (!is_match) begin
              good_run <= 1'b0;
            end else if (good_run == 1'(RECOVER_MATCHES - 1)) begin
              st       <= TRACK;
              good_run <= 1'b0;
            end else begin
              good_run <= good_run + 1'b1;
            end
          end
        end
        default: begin
          st       <= IDLE;
          good_run <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(WRAP_CNT_W)) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (wrap_ev),
    .cnt (wrap_count)
  );

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (mismatch_ev),
    .cnt (err_count)
  );

endmodule

// File: tb/tb_count_seq_checker.sv
// Randomized bench for count_seq_checker against a behavioural reference model.
module tb_count_seq_checker;

  localparam int W     = 4;
  localparam int WC_W  = 3;
  localparam int EC_W  = 2;
  localparam int CMOD  = 1 << W;
  localparam int WMAX  = (1 << WC_W) - 1;
  localparam int EMAX  = (1 << EC_W) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            valid_in = 1'b0;
  logic            clear = 1'b0;
  logic [W-1:0]    count_in = '0;
  logic            wrap_pulse;
  logic            err_pulse;
  logic            err_sticky;
  logic [WC_W-1:0] wrap_count;
  logic [EC_W-1:0] err_count;
  logic [1:0]      state;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_on = 1'b0;

  int wp_hits;
  int wp_at;
  int ctr;

  always #5 clk = ~clk;

  count_seq_checker #(
    .WIDTH      (W),
    .WRAP_CNT_W (WC_W),
    .ERR_CNT_W  (EC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .count_in   (count_in),
    .valid_in   (valid_in),
    .clear      (clear),
    .wrap_pulse (wrap_pulse),
    .wrap_count (wrap_count),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .err_sticky (err_sticky),
    .state      (state)
  );

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: 0 = not tracking, 1 = healthy, 2 = recovering.
  int m_state = 0;
  int m_prev  = 0;
  int m_run   = 0;
  int m_wc    = 0;
  int m_ec    = 0;
  bit m_wp    = 1'b0;
  bit m_ep    = 1'b0;
  bit m_st    = 1'b0;

  always @(posedge clk) begin
    bit mt;
    bit ev_err;
    bit ev_wrap;
    if (!rst) begin
      m_state = 0; m_prev = 0; m_run = 0;
      m_wc = 0; m_ec = 0; m_wp = 0; m_ep = 0; m_st = 0;
    end else begin
      mt      = (int'(count_in) == (m_prev + 1) % CMOD);
      ev_err  = valid_in && (m_state != 0) && !mt;
      ev_wrap = valid_in && (m_state == 1) && mt && (count_in == 0);
      m_ep = ev_err;
      m_wp = ev_wrap;
      if (clear) begin
        m_wc = 0; m_ec = 0; m_st = 0;
      end else begin
        if (ev_err && m_ec < EMAX) m_ec++;
        if (ev_wrap && m_wc < WMAX) m_wc++;
        if (ev_err) m_st = 1;
      end
      if (!valid_in) begin
        m_state = 0;
        m_run   = 0;
      end else if (m_state == 0) begin
        m_prev  = int'(count_in);
        m_state = 1;
      end else begin
        m_prev = int'(count_in);
        if (!mt) begin
          m_state = 2;
          m_run   = 0;
        end else if (m_state == 2) begin
          m_run++;
          if (m_run >= 2) begin
            m_state = 1;
            m_run   = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_on) begin
      chk("state",      state,      m_state);
      chk("wrap_pulse", wrap_pulse, m_wp);
      chk("wrap_count", wrap_count, m_wc);
      chk("err_pulse",  err_pulse,  m_ep);
      chk("err_count",  err_count,  m_ec);
      chk("err_sticky", err_sticky, m_st);
    end
  end

  task automatic drive(input bit r, input bit v, input int c, input bit cl);
    rst      = r;
    valid_in = v;
    count_in = W'(c);
    clear    = cl;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset and idle
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, $urandom_range(0, CMOD - 1), 1'b0);
      check_on = 1'b1;
    end
    chk("rst_state", state, 0);
    chk("rst_wrap_count", wrap_count, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_pulses", {wrap_pulse, err_pulse, err_sticky}, 0);
    drive(1'b1, 1'b0, 3, 1'b0);
    drive(1'b1, 1'b0, 7, 1'b0);
    chk("idle_hold_state", state, 0);

    // Clean run 0..15,0,1
    wp_hits = 0;
    wp_at   = -1;
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, 1'b1, i % CMOD, 1'b0);
      if (wrap_pulse === 1'b1) begin
        wp_hits++;
        wp_at = i;
      end
    end
    chk("clean_wrap_pulses", wp_hits, 1);
    chk("clean_wrap_idx", wp_at, 16);
    chk("clean_wrap_count", wrap_count, 1);
    chk("clean_err_count", err_count, 0);

    // Fault and recovery
    drive(1'b1, 1'b0, 0, 1'b1);
    drive(1'b1, 1'b1, 3, 1'b0);
    drive(1'b1, 1'b1, 4, 1'b0);
    chk("fr_state_4", state, 1);
    drive(1'b1, 1'b1, 9, 1'b0);
    chk("fr_err_pulse_9", err_pulse, 1);
    chk("fr_state_9", state, 2);
    drive(1'b1, 1'b1, 10, 1'b0);
    chk("fr_state_10", state, 2);
    chk("fr_err_pulse_10", err_pulse, 0);
    drive(1'b1, 1'b1, 11, 1'b0);
    chk("fr_state_11", state, 1);
    chk("fr_err_count", err_count, 1);
    chk("fr_err_sticky", err_sticky, 1);

    // Upstream reset gap
    drive(1'b1, 1'b0, 0, 1'b1);
    drive(1'b1, 1'b1, 5, 1'b0);
    drive(1'b1, 1'b1, 6, 1'b0);
    drive(1'b1, 1'b1, 7, 1'b0);
    chk("gap_state_track", state, 1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 0, 1'b0);
    chk("gap_state_idle", state, 0);
    drive(1'b1, 1'b1, 0, 1'b0);
    drive(1'b1, 1'b1, 1, 1'b0);
    chk("gap_state_retrack", state, 1);
    chk("gap_err_count", err_count, 0);

    // Saturation and clear priority
    drive(1'b1, 1'b0, 0, 1'b1);
    drive(1'b1, 1'b1, 0, 1'b0);
    drive(1'b1, 1'b1, 5, 1'b0);
    drive(1'b1, 1'b1, 10, 1'b0);
    drive(1'b1, 1'b1, 2, 1'b0);
    drive(1'b1, 1'b1, 8, 1'b0);
    drive(1'b1, 1'b1, 13, 1'b0);
    chk("sat_err_count", err_count, 3);
    drive(1'b1, 1'b1, 1, 1'b1);
    chk("clr_err_count", err_count, 0);
    chk("clr_err_sticky", err_sticky, 0);
    chk("clr_err_pulse", err_pulse, 1);

    // Reset mid-FAULT
    drive(1'b1, 1'b1, 7, 1'b0);
    drive(1'b1, 1'b1, 12, 1'b0);
    chk("mf_state", state, 2);
    chk("mf_err_count", err_count, 2);
    drive(1'b0, 1'b1, $urandom_range(0, CMOD - 1), 1'b1);
    chk("mf_rst_state", state, 0);
    chk("mf_rst_counts", {wrap_count, err_count}, 0);
    chk("mf_rst_flags", {wrap_pulse, err_pulse, err_sticky}, 0);

    // Randomized run against the model
    ctr = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) ctr = $urandom_range(0, CMOD - 1);
      else ctr = (ctr + 1) % CMOD;
      drive($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0, ctr,
            $urandom_range(0, 49) == 0);
    end

    check_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
